// File: rtl/sample_capture.sv
// Triggered sample recorder: captures prescaled probe samples into a
// non-wrapping memory, then streams them out over valid/ready.
module sample_capture #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 256,
    parameter int PRESCALE_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_run,
    input  logic [PRESCALE_W-1:0]   i_prescale,
    input  logic                    i_rd_ready,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_rd_last,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  run_q;
    logic [PRESCALE_W-1:0] pre;
    logic [PRESCALE_W-1:0] pcnt;
    logic [AW-1:0]         wptr;
    logic [CW-1:0]         rptr;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic run_start;
    logic start;
    logic tick;
    logic we;
    logic xfer;
    logic load;

    assign run_start = i_run & ~run_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (run_start) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (!i_run || o_full) begin
                    state_nxt = (o_count != '0) ? READOUT : IDLE;
                end
            end
            READOUT: begin
                if (xfer && o_rd_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state != IDLE);
        start  = (state == IDLE) && run_start;
        tick   = (pcnt == '0);
        we     = (state == CAPTURE) && tick && i_run && (o_count < DEPTH_C);
        xfer   = o_rd_valid && i_rd_ready;
        // refill the output register when it is empty or being drained
        load   = (state == READOUT) && (!o_rd_valid || xfer) && (rptr < o_count);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_q      <= 1'b0;
            pre        <= '0;
            pcnt       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            o_count    <= '0;
            o_full     <= 1'b0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_rd_last  <= 1'b0;
        end else begin
            run_q <= i_run;
            if (start) begin
                wptr    <= '0;
                rptr    <= '0;
                o_count <= '0;
                o_full  <= 1'b0;
                pcnt    <= '0;
                pre     <= i_prescale;
            end
            if (state == CAPTURE) begin
                pcnt <= (pcnt == pre) ? '0 : pcnt + 1'b1;
            end
            if (we) begin
                wptr    <= wptr + 1'b1;
                o_count <= o_count + 1'b1;
                if (o_count == DEPTH_C - 1'b1) o_full <= 1'b1;
            end
            if (load) begin
                o_rd_data  <= mem[rptr[AW-1:0]];
                o_rd_valid <= 1'b1;
                o_rd_last  <= (rptr == o_count - 1'b1);
                rptr       <= rptr + 1'b1;
            end else if (xfer) begin
                o_rd_valid <= 1'b0;
                o_rd_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) mem[wptr] <= i_data;
    end

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: vector table plus scoreboarded readout,
// with a DEPTH=4 instance for the memory-full corner.
module tb_sample_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_a;
    logic        run_b;
    logic        ready;
    logic [7:0]  din;
    logic [15:0] prescale;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, last_a, last_b;
    logic       full_a, full_b, busy_a, busy_b;
    logic [8:0] count_a;
    logic [2:0] count_b;

    bit         sel;
    logic [7:0] rd_data;
    logic       rd_valid, rd_last, full, busy;
    logic [8:0] count;

    int passed = 0;
    int total  = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sample_capture #(.WIDTH(8), .DEPTH(256), .PRESCALE_W(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_run(run_a),
        .i_prescale(prescale), .i_rd_ready(ready),
        .o_rd_data(data_a), .o_rd_valid(valid_a), .o_rd_last(last_a),
        .o_count(count_a), .o_full(full_a), .o_busy(busy_a)
    );

    sample_capture #(.WIDTH(8), .DEPTH(4), .PRESCALE_W(16)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_data(din), .i_run(run_b),
        .i_prescale(prescale), .i_rd_ready(ready),
        .o_rd_data(data_b), .o_rd_valid(valid_b), .o_rd_last(last_b),
        .o_count(count_b), .o_full(full_b), .o_busy(busy_b)
    );

    always_comb begin
        rd_data  = sel ? data_b  : data_a;
        rd_valid = sel ? valid_b : valid_a;
        rd_last  = sel ? last_b  : last_a;
        full     = sel ? full_b  : full_a;
        busy     = sel ? busy_b  : busy_a;
        count    = sel ? {6'd0, count_b} : count_a;
    end

    typedef struct {
        bit         s;
        int         pre;
        int         n;
        int         base;
        logic [3:0] pat;
        int         ecount;
        bit         efull;
    } vec_t;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_run(input logic v);
        run_a = v & ~sel;
        run_b = v & sel;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_data"}, rd_data, 0);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_last"}, rd_last, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_capture(input bit s, input int pre, input int n, input int base);
        int dep = s ? 4 : 256;
        int mc = 0;
        sel = s;
        prescale = 16'(pre);
        rst = 1'b0;
        set_run(1'b1);
        step();
        // a changed prescale must not disturb the running capture
        prescale = 16'hFFFF ^ 16'(pre);
        for (int k = 0; k < n; k++) begin
            din = 8'(base + k);
            set_run(1'b1);
            if ((k % (pre + 1)) == 0 && mc < dep) begin
                q.push_back(din);
                mc++;
            end
            step();
        end
        set_run(1'b0);
        din = 8'hEE;
        step();
    endtask

    task automatic drain(input logic [3:0] pat, input int abort);
        int beats = 0;
        int first = -1;
        bit done = 0;
        bit hold = 0;
        logic [7:0] hd;
        logic hl;
        for (int c = 0; c < 200 && !done; c++) begin
            ready = pat[c % 4];
            if (hold) begin
                chk("stall_valid", rd_valid, 1);
                chk("stall_data", rd_data, hd);
                chk("stall_last", rd_last, hl);
            end
            hold = 0;
            if (rd_valid && first < 0) begin
                first = c;
                chk("first_valid_latency_ok", first <= 2, 1);
            end
            if (rd_valid && ready) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("rd_data", rd_data, q.pop_front());
                    chk("rd_last", rd_last, q.size() == 0);
                end
                beats++;
                if (rd_last) done = 1;
            end else if (rd_valid) begin
                hold = 1;
                hd = rd_data;
                hl = rd_last;
            end
            step();
            if (abort > 0 && beats == abort) done = 1;
        end
        if (!done) chk("drain_timeout", 1, 0);
        ready = 1'b0;
    endtask

    initial begin
        vec_t vt[6];
        vt[0] = '{0, 0, 5, 1,     4'b1111, 5, 0};
        vt[1] = '{0, 2, 9, 0,     4'b1111, 3, 0};
        vt[2] = '{0, 0, 6, 8'h40, 4'b1001, 6, 0};
        vt[3] = '{0, 3, 0, 0,     4'b1111, 0, 0};
        vt[4] = '{0, 1, 7, 8'h80, 4'b0110, 4, 0};
        vt[5] = '{1, 0, 3, 8'hA0, 4'b1011, 3, 0};

        rst = 1'b1;
        sel = 0;
        run_a = 0;
        run_b = 0;
        ready = 0;
        din = 0;
        prescale = 0;
        step();
        step();
        chk_zero("rst_a");
        sel = 1;
        chk_zero("rst_b");
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            q.delete();
            do_capture(vt[i].s, vt[i].pre, vt[i].n, vt[i].base);
            chk("cap_count", count, vt[i].ecount);
            chk("cap_full", full, vt[i].efull);
            chk("cap_busy", busy, vt[i].ecount != 0);
            chk("cap_valid", rd_valid, 0);
            if (vt[i].ecount != 0) begin
                drain(vt[i].pat, 0);
                chk("end_valid", rd_valid, 0);
                chk("end_busy", busy, 0);
                chk("end_count_kept", count, vt[i].ecount);
                chk("sb_empty", q.size(), 0);
            end else begin
                for (int j = 0; j < 3; j++) begin
                    chk("nocap_valid", rd_valid, 0);
                    chk("nocap_busy", busy, 0);
                    step();
                end
            end
            step();
        end

        // memory fills with run still high: no wrap, readout starts anyway
        q.delete();
        sel = 1;
        prescale = 0;
        set_run(1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            din = 8'(8'h50 + k);
            if (k < 4) q.push_back(din);
            if (k == 4) begin
                chk("full_flag", full, 1);
                chk("full_count", count, 4);
            end
            step();
        end
        chk("full_readout_busy", busy, 1);
        chk("full_count_held", count, 4);
        drain(4'b1111, 0);
        chk("full_end_busy", busy, 0);
        step();
        step();
        chk("no_restart_busy", busy, 0);
        chk("full_kept", full, 1);
        set_run(1'b0);
        step();

        // reset mid-readout, then start with run already high at release
        q.delete();
        do_capture(0, 0, 5, 8'h21);
        chk("pre_abort_count", count, 5);
        drain(4'b1111, 2);
        rst = 1'b1;
        step();
        chk_zero("abort");
        q.delete();
        set_run(1'b1);
        step();
        chk_zero("rst_hold");
        do_capture(0, 0, 3, 8'h30);
        chk("restart_count", count, 3);
        drain(4'b1111, 0);
        chk("restart_busy", busy, 0);
        chk("restart_sb", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
